// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder/subtractor.
package adder_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_e;

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry slice; also exposes the carry into its MSB.
module rca_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] o_o,
    output logic         c_o,
    output logic         c_msb_o
);

    logic [W:0] carry;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        carry    = '0;
        o_o      = '0;
        carry[0] = c_i;
        for (int i = 0; i < W; i++) begin
            o_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = carry[W];
    assign c_msb_o = carry[W - 1];

endmodule

// File: rtl/pipelined_adder.sv
// N-bit adder/subtractor with the carry chain cut into STAGES registered ripple slices,
// valid/ready handshake and bubble-collapsing stall logic.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    input  op_e          op_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] o_o,
    output logic         c_o,
    output logic         ovf_o
);

    localparam int W = N / STAGES;

    if (N % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must divide N");
    end

    logic [N-1:0]        b_eff;
    logic                cin_eff;

    logic [STAGES-1:0]   vld_q;
    logic [N-1:0]        a_q   [STAGES];
    logic [N-1:0]        b_q   [STAGES];
    logic [N-1:0]        res_q [STAGES];
    logic [STAGES-1:0]   cy_q;
    logic                cmsb_q;

    logic [N-1:0]        a_in   [STAGES];
    logic [N-1:0]        b_in   [STAGES];
    logic [N-1:0]        res_in [STAGES];
    logic [N-1:0]        res_d  [STAGES];
    logic [STAGES-1:0]   cin;
    logic [STAGES-1:0]   vld_in;
    logic [W-1:0]        sum    [STAGES];
    logic [STAGES-1:0]   cout;
    logic [STAGES-1:0]   cmsb;
    logic [STAGES-1:0]   load;
    logic                all_full;

    assign b_eff   = (op_i == SUB) ? ~b_i : b_i;
    assign cin_eff = (op_i == SUB) ? 1'b1 : c_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_in[k]   = a_i;
            assign b_in[k]   = b_eff;
            assign cin[k]    = cin_eff;
            assign vld_in[k] = valid_i;
            assign res_in[k] = '0;
        end else begin : g_next
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign cin[k]    = cy_q[k-1];
            assign vld_in[k] = vld_q[k-1];
            assign res_in[k] = res_q[k-1];
        end

        rca_slice #(.W(W)) u_slice (
            .a_i     (a_in[k][k*W +: W]),
            .b_i     (b_in[k][k*W +: W]),
            .c_i     (cin[k]),
            .o_o     (sum[k]),
            .c_o     (cout[k]),
            .c_msb_o (cmsb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res_d[k]            = res_in[k];
            res_d[k][k*W +: W]  = sum[k];
        end
    end

    // Stage k may load unless it and every stage after it are full and the sink stalls.
    always_comb begin
        all_full = 1'b1;
        load     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & vld_q[k];
            load[k]  = ready_i | ~all_full;
        end
    end

    // NOTE: state uses non-blocking assignments, and the data registers are reset too so outputs read 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            cy_q   <= '0;
            cmsb_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    vld_q[k] <= vld_in[k];
                    if (vld_in[k]) begin
                        a_q[k]   <= a_in[k];
                        b_q[k]   <= b_in[k];
                        res_q[k] <= res_d[k];
                        cy_q[k]  <= cout[k];
                    end
                end
            end
            if (load[STAGES-1] && vld_in[STAGES-1]) begin
                cmsb_q <= cmsb[STAGES-1];
            end
        end
    end

    assign ready_o = load[0];
    assign valid_o = vld_q[STAGES-1];
    assign o_o     = res_q[STAGES-1];
    assign c_o     = cy_q[STAGES-1];
    assign ovf_o   = cmsb_q ^ cy_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded bench: an 8-bit/2-stage instance plus 16-bit
// instances with STAGES=1 and STAGES=8 fed from a shared stimulus bus.
module tb_pipelined_adder;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // 8-bit, 2-stage instance
    logic       v8, rdy8, c8, r8o, vo8, co8, ov8;
    logic [7:0] a8, b8, o8;
    op_e        op8;

    pipelined_adder #(.N(8), .STAGES(2)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v8), .ready_o(r8o),
        .a_i(a8), .b_i(b8), .c_i(c8), .op_i(op8),
        .valid_o(vo8), .ready_i(rdy8), .o_o(o8), .c_o(co8), .ovf_o(ov8)
    );

    // 16-bit instances sharing one input bus
    logic        v16, rdy16, c16;
    logic [15:0] a16, b16;
    op_e         op16;
    logic        ro_s1, vo_s1, co_s1, ov_s1, ro_s8, vo_s8, co_s8, ov_s8;
    logic [15:0] o_s1, o_s8;

    pipelined_adder #(.N(16), .STAGES(1)) u_dut_s1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v16), .ready_o(ro_s1),
        .a_i(a16), .b_i(b16), .c_i(c16), .op_i(op16),
        .valid_o(vo_s1), .ready_i(rdy16), .o_o(o_s1), .c_o(co_s1), .ovf_o(ov_s1)
    );

    pipelined_adder #(.N(16), .STAGES(8)) u_dut_s8 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v16), .ready_o(ro_s8),
        .a_i(a16), .b_i(b16), .c_i(c16), .op_i(op16),
        .valid_o(vo_s8), .ready_i(rdy16), .o_o(o_s8), .c_o(co_s8), .ovf_o(ov_s8)
    );

    // Reference: returns {ovf, carry, result[15:0]} for an n-bit add/sub.
    function automatic logic [17:0] model(int n, logic [15:0] a, logic [15:0] b, logic c, logic sub);
        logic [15:0] mask, am, bb;
        logic [16:0] s;
        logic        cin, co, ov;
        mask = (n == 16) ? 16'hFFFF : 16'h00FF;
        am   = a & mask;
        bb   = (sub ? ~b : b) & mask;
        cin  = sub ? 1'b1 : c;
        s    = {1'b0, am} + {1'b0, bb} + {16'h0, cin};
        co   = s[n];
        ov   = (am[n-1] == bb[n-1]) && (s[n-1] != am[n-1]);
        return {ov, co, s[15:0] & mask};
    endfunction

    // Scoreboards sample at the falling edge, where inputs and outputs are stable.
    logic [17:0] q8[$], q_s1[$], q_s8[$];
    int          sent8 = 0, recv8 = 0, first8 = -1, last8 = -1;
    int          sent_s1 = 0, recv_s1 = 0, first_s1 = -1, last_s1 = -1;
    int          sent_s8 = 0, recv_s8 = 0, first_s8 = -1, last_s8 = -1;
    logic        stall8 = 1'b0;
    logic [9:0]  hold8;

    always @(negedge clk) begin
        logic [17:0] exp8;
        if (!rst_n) begin
            stall8 = 1'b0;
        end else begin
            if (stall8) begin
                total++;
                if (!(vo8 === 1'b1 && {co8, ov8, o8} === hold8)) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b %b%b %h want v=1 %h", vo8, co8, ov8, o8, hold8);
                end
            end
            stall8 = vo8 && !rdy8;
            hold8  = {co8, ov8, o8};
            if (v8 && r8o) begin
                q8.push_back(model(8, {8'h00, a8}, {8'h00, b8}, c8, op8 == SUB));
                sent8++;
            end
            if (vo8 && rdy8) begin
                total++;
                if (q8.size() == 0) begin
                    bad++;
                    $display("FAIL sb8_unexpected: got %h want no result", o8);
                end else begin
                    exp8 = q8.pop_front();
                    if ({ov8, co8, 8'h00, o8} !== exp8) begin
                        bad++;
                        $display("FAIL sb8: got %h want %h", {ov8, co8, 8'h00, o8}, exp8);
                    end
                end
                recv8++;
                if (first8 < 0) first8 = cyc;
                last8 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n) begin
            if (v16 && ro_s1) begin
                q_s1.push_back(model(16, a16, b16, c16, op16 == SUB));
                sent_s1++;
            end
            if (vo_s1 && rdy16) begin
                total++;
                e = (q_s1.size() != 0) ? q_s1.pop_front() : 18'h3FFFF;
                if ({ov_s1, co_s1, o_s1} !== e) begin
                    bad++;
                    $display("FAIL sb_s1: got %h want %h", {ov_s1, co_s1, o_s1}, e);
                end
                recv_s1++;
                if (first_s1 < 0) first_s1 = cyc;
                last_s1 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n) begin
            if (v16 && ro_s8) begin
                q_s8.push_back(model(16, a16, b16, c16, op16 == SUB));
                sent_s8++;
            end
            if (vo_s8 && rdy16) begin
                total++;
                e = (q_s8.size() != 0) ? q_s8.pop_front() : 18'h3FFFF;
                if ({ov_s8, co_s8, o_s8} !== e) begin
                    bad++;
                    $display("FAIL sb_s8: got %h want %h", {ov_s8, co_s8, o_s8}, e);
                end
                recv_s8++;
                if (first_s8 < 0) first_s8 = cyc;
                last_s8 = cyc;
            end
        end
    end

    // Present the current a8/b8/c8/op8 until accepted; returns at posedge+1.
    task automatic send8();
        logic acc = 1'b0;
        int   guard = 0;
        v8 = 1'b1;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = v8 && r8o;
            @(posedge clk);
            #1;
            guard++;
        end
        v8 = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send8_timeout: got no acceptance want acceptance");
        end
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!vo8 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Random operand sets; rand_valid inserts idle cycles between them.
    task automatic drive8(int n, bit rand_valid);
        for (int i = 0; i < n; i++) begin
            logic acc = 1'b0;
            int   guard = 0;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 1'($urandom);
            op8 = op_e'(1'($urandom));
            v8  = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = v8 && r8o;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && !v8) v8 = ($urandom_range(0, 1) == 1);
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL drive8_timeout: item %0d got no acceptance want acceptance", i);
                v8 = 1'b0;
                return;
            end
        end
        v8 = 1'b0;
    endtask

    task automatic drain8();
        int guard = 0;
        while (recv8 != sent8 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({vo8, co8, ov8, o8} !== 11'h0) begin
            bad++;
            $display("FAIL reset_out8: got %h want 0", {vo8, co8, ov8, o8});
        end
        total++;
        if ({vo_s1, co_s1, ov_s1, o_s1, vo_s8, co_s8, ov_s8, o_s8} !== 38'h0) begin
            bad++;
            $display("FAIL reset_out16: got %h %h want 0 0", o_s1, o_s8);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({r8o, ro_s1, ro_s8, vo8} !== 4'b1110) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1110", {r8o, ro_s1, ro_s8, vo8});
        end
    endtask

    task automatic test_add8();
        logic [7:0] ta [5], tb [5], to [5];
        logic       tc [5], tco [5], tov [5];
        int         lat;
        ta  = '{8'h3C, 8'hFF, 8'h0F, 8'h80, 8'h7F};
        tb  = '{8'h47, 8'h01, 8'h01, 8'h80, 8'h00};
        tc  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        to  = '{8'h84, 8'h00, 8'h10, 8'h00, 8'h80};
        tco = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        tov = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        rdy8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a8 = ta[i]; b8 = tb[i]; c8 = tc[i]; op8 = ADD;
            send8();
            wait8(lat);
            total++;
            if (lat != 1 || vo8 !== 1'b1) begin
                bad++;
                $display("FAIL add_latency[%0d]: got %0d edges want 1", i, lat);
            end
            total++;
            if ({co8, ov8, o8} !== {tco[i], tov[i], to[i]}) begin
                bad++;
                $display("FAIL add[%0d]: got c=%b v=%b o=%h want c=%b v=%b o=%h",
                         i, co8, ov8, o8, tco[i], tov[i], to[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sub8();
        logic [7:0] ta [4], tb [4], to [4];
        logic       tc [4], tco [4], tov [4];
        int         lat;
        ta  = '{8'h05, 8'h80, 8'h10, 8'h00};
        tb  = '{8'h07, 8'h01, 8'h01, 8'h00};
        tc  = '{1'b0,  1'b1,  1'b0,  1'b0};
        to  = '{8'hFE, 8'h7F, 8'h0F, 8'h00};
        tco = '{1'b0,  1'b1,  1'b1,  1'b1};
        tov = '{1'b0,  1'b1,  1'b0,  1'b0};
        rdy8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a8 = ta[i]; b8 = tb[i]; c8 = tc[i]; op8 = SUB;
            send8();
            wait8(lat);
            total++;
            if ({vo8, co8, ov8, o8} !== {1'b1, tco[i], tov[i], to[i]}) begin
                bad++;
                $display("FAIL sub[%0d]: got v=%b c=%b ov=%b o=%h want v=1 c=%b ov=%b o=%h",
                         i, vo8, co8, ov8, o8, tco[i], tov[i], to[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back8();
        int s0 = sent8, r0 = recv8;
        rdy8   = 1'b1;
        first8 = -1;
        drive8(16, 1'b0);
        drain8();
        total++;
        if (sent8 - s0 != 16 || recv8 - r0 != 16 || last8 - first8 != 15) begin
            bad++;
            $display("FAIL b2b8: got sent=%0d recv=%0d span=%0d want 16 16 15",
                     sent8 - s0, recv8 - r0, last8 - first8);
        end
    endtask

    task automatic test_backpressure8();
        int s0 = sent8, r0 = recv8;
        fork
            drive8(6, 1'b0);
            begin
                logic [9:0] hold;
                rdy8 = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                total++;
                if ({r8o, vo8} !== 2'b01) begin
                    bad++;
                    $display("FAIL bp_full: got ready_o=%b valid_o=%b want 0 1", r8o, vo8);
                end
                hold = {co8, ov8, o8};
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    total++;
                    if ({r8o, vo8, co8, ov8, o8} !== {2'b01, hold}) begin
                        bad++;
                        $display("FAIL bp_hold[%0d]: got r=%b v=%b %b%b %h want r=0 v=1 %h",
                                 i, r8o, vo8, co8, ov8, o8, hold);
                    end
                end
                @(posedge clk);
                #1;
                rdy8 = 1'b1;
            end
        join
        drain8();
        total++;
        if (sent8 - s0 != 6 || recv8 - r0 != 6) begin
            bad++;
            $display("FAIL bp_count: got sent=%0d recv=%0d want 6 6", sent8 - s0, recv8 - r0);
        end
    endtask

    task automatic test_random8();
        int s0 = sent8, r0 = recv8;
        bit done = 1'b0;
        fork
            begin
                drive8(1000, 1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rdy8 = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                rdy8 = 1'b1;
            end
        join
        drain8();
        total++;
        if (sent8 - s0 != 1000 || recv8 - r0 != 1000) begin
            bad++;
            $display("FAIL rand_count: got sent=%0d recv=%0d want 1000 1000", sent8 - s0, recv8 - r0);
        end
    endtask

    task automatic test_reset_midstream();
        int lat;
        rdy8 = 1'b1;
        v8   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'(8'h11 * (i + 1)); b8 = 8'h22; c8 = 1'b0; op8 = ADD;
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({vo8, co8, ov8, o8} !== 11'h0) begin
            bad++;
            $display("FAIL midreset_out: got %h want 0", {vo8, co8, ov8, o8});
        end
        v8 = 1'b0;
        q8.delete();
        q_s1.delete();
        q_s8.delete();
        sent8 = recv8;
        sent_s1 = recv_s1;
        sent_s8 = recv_s8;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (vo8 !== 1'b0) begin
                bad++;
                $display("FAIL midreset_stale[%0d]: got valid_o=%b want 0", i, vo8);
            end
        end
        @(posedge clk);
        #1;
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; op8 = ADD;
        send8();
        wait8(lat);
        total++;
        if ({vo8, co8, ov8, o8} !== {3'b100, 8'h46}) begin
            bad++;
            $display("FAIL midreset_after: got v=%b %b%b %h want v=1 00 46", vo8, co8, ov8, o8);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back16();
        int a1 = sent_s1, r1 = recv_s1, a8x = sent_s8, r8x = recv_s8;
        int guard = 0;
        rdy16    = 1'b1;
        first_s1 = -1;
        first_s8 = -1;
        for (int i = 0; i < 16; i++) begin
            v16  = 1'b1;
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            c16  = 1'($urandom);
            op16 = op_e'(1'($urandom));
            @(posedge clk);
            #1;
        end
        v16 = 1'b0;
        while ((recv_s1 - r1 < 16 || recv_s8 - r8x < 16) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (sent_s1 - a1 != 16 || recv_s1 - r1 != 16 || last_s1 - first_s1 != 15) begin
            bad++;
            $display("FAIL b2b_s1: got sent=%0d recv=%0d span=%0d want 16 16 15",
                     sent_s1 - a1, recv_s1 - r1, last_s1 - first_s1);
        end
        total++;
        if (sent_s8 - a8x != 16 || recv_s8 - r8x != 16 || last_s8 - first_s8 != 15) begin
            bad++;
            $display("FAIL b2b_s8: got sent=%0d recv=%0d span=%0d want 16 16 15",
                     sent_s8 - a8x, recv_s8 - r8x, last_s8 - first_s8);
        end
        total++;
        if (first_s8 - first_s1 != 7) begin
            bad++;
            $display("FAIL b2b_latency_diff: got %0d want 7", first_s8 - first_s1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "timeout");
    end

    initial begin
        v8 = 1'b0; rdy8 = 1'b1; c8 = 1'b0; a8 = '0; b8 = '0; op8 = ADD;
        v16 = 1'b0; rdy16 = 1'b1; c16 = 1'b0; a16 = '0; b16 = '0; op16 = ADD;
        test_reset();
        test_add8();
        test_sub8();
        test_back_to_back8();
        test_backpressure8();
        test_random8();
        test_reset_midstream();
        test_back_to_back16();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
